// File: rtl/mips_datamemory_bs.sv
// Byte-addressable MIPS data memory: byte/half/word/full loads and stores,
// registered 1-cycle read, misalignment flag with saturating error counter.
module mips_datamemory_bs #(
  parameter int NBITS  = 32,
  parameter int ADDRSZ = 5
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     write_ena,
  input  logic                                     read_ena,
  input  logic [1:0]                               size,
  input  logic                                     sign_ext,
  input  logic [ADDRSZ+$clog2(NBITS/8)-1:0]        addr,
  input  logic [NBITS-1:0]                         data_wr,
  output logic [NBITS-1:0]                         data_rd,
  output logic                                     rd_valid,
  output logic                                     misaligned,
  output logic [7:0]                               err_count
);

  localparam int NBYTES = NBITS / 8;
  localparam int BSEL   = $clog2(NBYTES);
  localparam int AW     = ADDRSZ + BSEL;
  localparam int DEPTH  = 2 ** ADDRSZ;

  logic [NBITS-1:0]  mem [DEPTH];

  logic [ADDRSZ-1:0] word_idx;
  logic [BSEL-1:0]   byte_off;
  logic [BSEL+2:0]   shamt;
  logic              aligned;
  logic              sign_bit;
  logic [NBITS-1:0]  lane_mask;
  logic [NBITS-1:0]  rd_word;
  logic [NBITS-1:0]  shifted;
  logic [NBITS-1:0]  load_val;
  logic [NBITS-1:0]  new_word;

  assign word_idx = addr[AW-1:BSEL];
  assign byte_off = addr[BSEL-1:0];
  assign shamt    = {byte_off, 3'b000};
  assign rd_word  = mem[word_idx];
  assign shifted  = rd_word >> shamt;

  always_comb begin
    aligned   = 1'b1;
    lane_mask = '1;
    sign_bit  = shifted[NBITS-1];
    case (size)
      2'b00: begin
        lane_mask = NBITS'(8'hFF);
        sign_bit  = shifted[7];
      end
      2'b01: begin
        aligned   = ~byte_off[0];
        lane_mask = NBITS'(16'hFFFF);
        sign_bit  = shifted[15];
      end
      2'b10: begin
        aligned   = (byte_off[1:0] == 2'b00);
        lane_mask = NBITS'(32'hFFFF_FFFF);
        sign_bit  = shifted[31];
      end
      default: begin
        aligned   = (byte_off == '0);
        lane_mask = '1;
        sign_bit  = shifted[NBITS-1];
      end
    endcase
  end

  // Aligned accesses never straddle a word, so a plain shift places the lanes.
  always_comb begin
    load_val = shifted & lane_mask;
    if (sign_ext && sign_bit) begin
      load_val = load_val | ~lane_mask;
    end
    new_word = (rd_word & ~(lane_mask << shamt)) | ((data_wr & lane_mask) << shamt);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      data_rd    <= '0;
      rd_valid   <= 1'b0;
      misaligned <= 1'b0;
      err_count  <= 8'd0;
    end else begin
      rd_valid   <= 1'b0;
      misaligned <= 1'b0;
      if ((write_ena || read_ena) && !aligned) begin
        misaligned <= 1'b1;
        if (err_count != 8'hFF) begin
          err_count <= err_count + 8'd1;
        end
      end
      // Read uses the pre-edge word, giving read-before-write on collisions.
      if (read_ena && aligned) begin
        data_rd  <= load_val;
        rd_valid <= 1'b1;
      end
      if (write_ena && aligned) begin
        mem[word_idx] <= new_word;
      end
    end
  end

endmodule
